// File: rtl/rotation_engine.sv
`default_nettype none
// ============================================================================
// Module      : rotation_engine
// Description : Iterative CORDIC-style vector rotator. A small buffer holds
//               NUM_STEP sign words (NUM_SIGN direction bits each). Every
//               accepted (X,Y) vector is rotated through NUM_SIGN*NUM_STEP
//               shift-add micro-rotations, two per clock. No gain correction.
// Ports       : clk, rst           - clock, asynchronous active-high reset
//               sign_valid/sign_d  - sign word write strobe and data
//               sign_clr           - empties the sign buffer (IDLE only)
//               sign_full          - all NUM_STEP sign words loaded
//               in_valid/in_ready  - input vector handshake, in_X/in_Y data
//               out_valid/out_ready- result handshake, out_X/out_Y data
// Revision    : 1.0 - initial release
// ============================================================================
module rotation_engine #(
  parameter int DATA_LENGTH = 13,
  parameter int ITER_IDX    = 3,
  parameter int NUM_SIGN    = 2,
  parameter int NUM_STEP    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sign_valid,
  input  logic [NUM_SIGN-1:0]    sign_d,
  input  logic                   sign_clr,
  output logic                   sign_full,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_LENGTH-1:0] in_X,
  input  logic [DATA_LENGTH-1:0] in_Y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_LENGTH-1:0] out_X,
  output logic [DATA_LENGTH-1:0] out_Y
);

  localparam int c_STEP_W = (NUM_STEP > 1) ? $clog2(NUM_STEP) : 1;
  // Pointer must reach NUM_STEP itself so "full" is representable.
  localparam int c_PTR_W  = $clog2(NUM_STEP + 1);
  localparam logic [c_PTR_W-1:0]  c_FULL = c_PTR_W'(NUM_STEP);
  localparam logic [c_STEP_W-1:0] c_LAST = c_STEP_W'(NUM_STEP - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROT  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                         r_state;
  state_t                         w_next;
  logic [NUM_SIGN-1:0]            r_sign [NUM_STEP];
  logic [c_PTR_W-1:0]             r_wptr;
  logic [c_STEP_W-1:0]            r_step;
  logic signed [DATA_LENGTH-1:0]  r_x;
  logic signed [DATA_LENGTH-1:0]  r_y;
  logic [DATA_LENGTH-1:0]         r_out_x;
  logic [DATA_LENGTH-1:0]         r_out_y;

  logic                           w_full;
  logic                           w_accept;
  logic                           w_last;
  logic [NUM_SIGN-1:0]            w_d;
  logic [ITER_IDX-1:0]            w_i0;
  logic [ITER_IDX-1:0]            w_i1;
  logic signed [DATA_LENGTH-1:0]  w_x1;
  logic signed [DATA_LENGTH-1:0]  w_y1;
  logic signed [DATA_LENGTH-1:0]  w_x2;
  logic signed [DATA_LENGTH-1:0]  w_y2;

  assign w_full    = (r_wptr == c_FULL);
  assign sign_full = w_full;
  assign in_ready  = (r_state == S_IDLE) & w_full;
  assign w_accept  = in_valid & in_ready;
  assign w_last    = (r_step == c_LAST);
  assign out_valid = (r_state == S_DONE);
  assign out_X     = r_out_x;
  assign out_Y     = r_out_y;

  // Two micro-rotations per cycle: iteration 2*step, then 2*step+1 chained
  // on its result. Each uses the pre-update X and Y on both right-hand sides.
  always_comb begin
    w_d  = r_sign[r_step];
    w_i0 = ITER_IDX'({r_step, 1'b0});
    w_i1 = ITER_IDX'({r_step, 1'b1});
    if (w_d[0]) begin
      w_x1 = r_x + (r_y >>> w_i0);
      w_y1 = r_y - (r_x >>> w_i0);
    end else begin
      w_x1 = r_x - (r_y >>> w_i0);
      w_y1 = r_y + (r_x >>> w_i0);
    end
    if (w_d[1]) begin
      w_x2 = w_x1 + (w_y1 >>> w_i1);
      w_y2 = w_y1 - (w_x1 >>> w_i1);
    end else begin
      w_x2 = w_x1 - (w_y1 >>> w_i1);
      w_y2 = w_y1 + (w_x1 >>> w_i1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_next = S_ROT;
      S_ROT:   if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Sign buffer: clear wins over a same-cycle write; writes stop at full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      for (int k = 0; k < NUM_STEP; k++) begin
        r_sign[k] <= '0;
      end
    end else if ((r_state == S_IDLE) && sign_clr) begin
      r_wptr <= '0;
    end else if (sign_valid && !w_full) begin
      r_sign[r_wptr[c_STEP_W-1:0]] <= sign_d;
      r_wptr                       <= r_wptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_out_x <= '0;
      r_out_y <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_accept) begin
        r_x    <= in_X;
        r_y    <= in_Y;
        r_step <= '0;
      end else if (r_state == S_ROT) begin
        r_x    <= w_x2;
        r_y    <= w_y2;
        r_step <= w_last ? '0 : r_step + 1'b1;
        if (w_last) begin
          r_out_x <= w_x2;
          r_out_y <= w_y2;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rotation_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_rotation_engine
// Description : Directed bench for rotation_engine with hand-computed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rotation_engine;

  localparam int DL = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sign_valid = 1'b0;
  logic [1:0]    sign_d = 2'b00;
  logic          sign_clr = 1'b0;
  logic          sign_full;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DL-1:0] in_X = '0;
  logic [DL-1:0] in_Y = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DL-1:0] out_X;
  logic [DL-1:0] out_Y;

  int n_pass  = 0;
  int n_total = 0;
  int lat;

  rotation_engine #(
    .DATA_LENGTH(DL), .ITER_IDX(3), .NUM_SIGN(2), .NUM_STEP(4)
  ) dut (
    .clk(clk), .rst(rst),
    .sign_valid(sign_valid), .sign_d(sign_d), .sign_clr(sign_clr),
    .sign_full(sign_full),
    .in_valid(in_valid), .in_ready(in_ready), .in_X(in_X), .in_Y(in_Y),
    .out_valid(out_valid), .out_ready(out_ready), .out_X(out_X), .out_Y(out_Y)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sign(input logic [1:0] w);
    sign_d = w; sign_valid = 1'b1;
    tick();
    sign_valid = 1'b0;
  endtask

  // words[1:0] = entry0 ... words[7:6] = entry3
  task automatic load_signs(input logic [7:0] words);
    sign_clr = 1'b1; tick(); sign_clr = 1'b0;
    for (int k = 0; k < 4; k++) push_sign(words[2*k +: 2]);
  endtask

  // Presents one vector; returns cycles from acceptance until out_valid.
  task automatic rotate(input logic [DL-1:0] x, input logic [DL-1:0] y, output int cycles);
    in_X = x; in_Y = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_total++;
    if ({sign_full, in_ready, out_valid} !== 3'b000 || out_X !== '0 || out_Y !== '0)
      $display("FAIL reset_state: full/ready/valid=%b x=%0d y=%0d want 000 0 0",
               {sign_full, in_ready, out_valid}, out_X, out_Y);
    else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sign_load();
    push_sign(2'b11); push_sign(2'b11);
    // clear and write collide: clear must win
    sign_clr = 1'b1; sign_valid = 1'b1; sign_d = 2'b11;
    tick();
    sign_clr = 1'b0; sign_valid = 1'b0;
    n_total++;
    if (sign_full !== 1'b0) $display("FAIL clr_collide_full: got %b want 0", sign_full);
    else n_pass++;
    push_sign(2'b00); push_sign(2'b00); push_sign(2'b00);
    n_total++;
    if (sign_full !== 1'b0) $display("FAIL three_words_full: got %b want 0", sign_full);
    else n_pass++;
    push_sign(2'b00);
    n_total++;
    if ({sign_full, in_ready} !== 2'b11)
      $display("FAIL four_words_full_ready: got %b want 11", {sign_full, in_ready});
    else n_pass++;
    push_sign(2'b11);  // fifth write must be dropped
    n_total++;
    if (sign_full !== 1'b1) $display("FAIL fifth_word_full: got %b want 1", sign_full);
    else n_pass++;
  endtask

  task automatic test_rot_zero_signs();
    rotate(13'd256, 13'd0, lat);
    n_total++;
    if (lat !== 4) $display("FAIL zero_latency: got %0d want 4", lat);
    else n_pass++;
    n_total++;
    if (out_X !== DL'(-68) || out_Y !== DL'(414))
      $display("FAIL zero_result: got (%0d,%0d) want (-68,414)", $signed(out_X), $signed(out_Y));
    else n_pass++;
    handshake();
  endtask

  task automatic test_retention();
    out_ready = 1'b1;  // held early: must not disturb ROT
    rotate(13'd0, 13'd0, lat);
    n_total++;
    if (lat !== 4 || out_X !== '0 || out_Y !== '0)
      $display("FAIL retain_zero_vec: got lat=%0d (%0d,%0d) want lat=4 (0,0)",
               lat, $signed(out_X), $signed(out_Y));
    else n_pass++;
    tick();
    out_ready = 1'b0;
    n_total++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL retain_back_idle: valid/ready=%b want 01", {out_valid, in_ready});
    else n_pass++;
    rotate(13'd256, 13'd0, lat);
    n_total++;
    if (lat !== 4 || out_X !== DL'(-68) || out_Y !== DL'(414))
      $display("FAIL retain_second_vec: got lat=%0d (%0d,%0d) want lat=4 (-68,414)",
               lat, $signed(out_X), $signed(out_Y));
    else n_pass++;
    handshake();
  endtask

  task automatic test_rot_one_signs();
    load_signs(8'b11_11_11_11);
    rotate(13'd0, 13'd256, lat);
    n_total++;
    if (lat !== 4 || out_X !== DL'(414) || out_Y !== DL'(-68))
      $display("FAIL ones_result: got lat=%0d (%0d,%0d) want lat=4 (414,-68)",
               lat, $signed(out_X), $signed(out_Y));
    else n_pass++;
    handshake();
  endtask

  task automatic test_back_pressure();
    // entries: e0=10 e1=01 e2=00 e3=11 ; (256,0) -> (405,112)
    load_signs(8'b11_00_01_10);
    rotate(13'd256, 13'd0, lat);
    n_total++;
    if (lat !== 4 || out_X !== DL'(405) || out_Y !== DL'(112))
      $display("FAIL mixed_result: got lat=%0d (%0d,%0d) want lat=4 (405,112)",
               lat, $signed(out_X), $signed(out_Y));
    else n_pass++;
    in_valid = 1'b1; in_X = 13'd100; in_Y = 13'd200; sign_clr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++;
      if ({out_valid, in_ready, sign_full} !== 3'b101 || out_X !== DL'(405) || out_Y !== DL'(112))
        $display("FAIL stall_cycle%0d: valid/ready/full=%b (%0d,%0d) want 101 (405,112)",
                 k, {out_valid, in_ready, sign_full}, $signed(out_X), $signed(out_Y));
      else n_pass++;
    end
    in_valid = 1'b0; sign_clr = 1'b0;
    handshake();
    n_total++;
    if ({out_valid, in_ready} !== 2'b01 || out_X !== DL'(405) || out_Y !== DL'(112))
      $display("FAIL release_idle: valid/ready=%b (%0d,%0d) want 01 (405,112)",
               {out_valid, in_ready}, $signed(out_X), $signed(out_Y));
    else n_pass++;
  endtask

  task automatic test_reset_mid_rot();
    in_X = 13'd256; in_Y = 13'd0; in_valid = 1'b1;
    tick();            // accepted
    in_valid = 1'b0;
    tick();            // first ROT update done, now in 2nd ROT cycle
    rst = 1'b1;
    #1;                // well before the next edge: reset is asynchronous
    n_total++;
    if ({out_valid, in_ready, sign_full} !== 3'b000 || out_X !== '0 || out_Y !== '0)
      $display("FAIL async_reset: valid/ready/full=%b (%0d,%0d) want 000 (0,0)",
               {out_valid, in_ready, sign_full}, $signed(out_X), $signed(out_Y));
    else n_pass++;
    tick();
    rst = 1'b0;
    tick(); tick();
    n_total++;
    if ({sign_full, in_ready, out_valid} !== 3'b000)
      $display("FAIL post_reset_no_signs: full/ready/valid=%b want 000",
               {sign_full, in_ready, out_valid});
    else n_pass++;
    for (int k = 0; k < 4; k++) push_sign(2'b00);
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reload_ready: got %b want 1", in_ready);
    else n_pass++;
    rotate(13'd256, 13'd0, lat);
    n_total++;
    if (lat !== 4 || out_X !== DL'(-68) || out_Y !== DL'(414))
      $display("FAIL post_reset_rot: got lat=%0d (%0d,%0d) want lat=4 (-68,414)",
               lat, $signed(out_X), $signed(out_Y));
    else n_pass++;
    handshake();
  endtask

  initial begin
    test_reset();
    test_sign_load();
    test_rot_zero_signs();
    test_retention();
    test_rot_one_signs();
    test_back_pressure();
    test_reset_mid_rot();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
